// File: rtl/mul_sequencer.sv
// Multi-cycle shift-and-add unsigned multiplier sequencer that stalls the fetch path while a MUL runs.
// Optional macro MUL_EARLY_TERM_EN: leave RUN as soon as no multiplier bits remain.
module mul_sequencer #(
    parameter int n = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [n-1:0]     a,
    input  logic [n-1:0]     b,
    output logic             stall,
    output logic             busy,
    output logic             done,
    output logic             w,
    output logic [2*n-1:0]   product
);

    localparam int CW = (n > 1) ? $clog2(n) : 1;
    localparam logic [CW-1:0] LAST = CW'(n - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           r_state;
    state_t           w_state_nxt;
    logic [2*n-1:0]   r_mcand;
    logic [2*n-1:0]   r_acc;
    logic [2*n-1:0]   w_acc_nxt;
    logic [n-1:0]     r_mplier;
    logic [n-1:0]     w_mplier_shr;
    logic [CW-1:0]    r_count;
    logic             w_last;

    assign w_acc_nxt    = r_mplier[0] ? (r_acc + r_mcand) : r_acc;
    assign w_mplier_shr = r_mplier >> 1;

`ifdef MUL_EARLY_TERM_EN
    assign w_last = (r_count == LAST) || (w_mplier_shr == '0);
`else
    assign w_last = (r_count == LAST);
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        stall       = 1'b0;
        busy        = 1'b0;
        done        = 1'b0;
        case (r_state)
            IDLE: begin
                stall = start;
                if (start) begin
                    w_state_nxt = RUN;
                end
            end
            RUN: begin
                stall = 1'b1;
                busy  = 1'b1;
                if (w_last) begin
                    w_state_nxt = DONE;
                end
            end
            DONE: begin
                // Stall drops here so the PC moves past the MUL in the same cycle the product is written.
                busy        = 1'b1;
                done        = 1'b1;
                w_state_nxt = IDLE;
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
        w = done;
    end

    // The final RUN edge captures the last partial sum straight into product, so it is valid on DONE entry.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_mcand  <= '0;
            r_acc    <= '0;
            r_mplier <= '0;
            r_count  <= '0;
            product  <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (start) begin
                        r_mcand  <= {{n{1'b0}}, a};
                        r_mplier <= b;
                        r_acc    <= '0;
                        r_count  <= '0;
                    end
                end
                RUN: begin
                    r_acc    <= w_acc_nxt;
                    r_mcand  <= r_mcand << 1;
                    r_mplier <= w_mplier_shr;
                    r_count  <= r_count + CW'(1);
                    if (w_last) begin
                        product <= w_acc_nxt;
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: doc/mul_sequencer.md
MUL_SEQUENCER -- requirements
Module: mul_sequencer

Interface
REQ-001 SHALL have parameter: n, default 8, datapath (register) width in bits.
REQ-002 SHALL have port: clk  input  1  system clock, all state updates on rising edge.
REQ-003 SHALL have port: reset  input  1  asynchronous, active-high reset.
REQ-004 SHALL have port: start  input  1  decoder request for a MUL instruction (opcode 3'b110) this cycle.
REQ-005 SHALL have port: a  input  n  multiplicand (Rd value), sampled only when start is accepted.
REQ-006 SHALL have port: b  input  n  multiplier (Rs value), sampled only when start is accepted.
REQ-007 SHALL have port: stall  output  1  freezes PC (overrides PCincr/PCrelbranch) and blocks decoder write-enable.
REQ-008 SHALL have port: busy  output  1  high while a multiply is in progress (state RUN or DONE).
REQ-009 SHALL have port: done  output  1  single-cycle completion pulse.
REQ-010 SHALL have port: w  output  1  register-file write-enable for product; equals done.
REQ-011 SHALL have port: product  output  2n  unsigned product; holds value until next completion.

Function
REQ-012 SHALL implement FSM states IDLE, RUN, DONE.
REQ-013 IDLE: start=1 at rising edge -> load mcand={n'b0,a}, mplier=b, acc=0, count=0; go RUN; else stay IDLE.
REQ-014 RUN, each edge: if mplier[0] then acc <= acc + mcand; mcand <= mcand<<1; mplier <= mplier>>1; count <= count+1.
REQ-015 RUN -> DONE on the edge where count==n-1 (n RUN cycles total); else stay RUN.
REQ-016 DONE: product <= acc on entry; done=w=1 for exactly this one cycle; unconditionally -> IDLE next edge.
REQ-017 Arithmetic: unsigned, 2n-bit accumulator; no truncation, no overflow possible; count width clog2(n).
REQ-018 stall = (IDLE & start) | RUN, combinational; low in DONE so PC advances past the MUL on the completing cycle.
REQ-019 busy = RUN | DONE, registered state decode.
REQ-020 start in RUN or DONE SHALL be ignored (no restart, no queueing); operands not resampled.
REQ-021 Latency: start high in cycle 0 -> RUN cycles 1..n -> done high in cycle n+1; next start accepted earliest in cycle n+2.
REQ-022 a, b changes after acceptance SHALL NOT affect the result.

Reset
REQ-023 reset=1 SHALL asynchronously force state=IDLE, acc=0, mcand=0, mplier=0, count=0, product=0.
REQ-024 During/after reset: stall=start-driven only (IDLE), busy=0, done=0, w=0.
REQ-025 Reset mid-RUN SHALL abort the operation with no done/w pulse; product reads 0.

Configuration
REQ-026 Macro MUL_EARLY_TERM_EN SHALL select early termination.
REQ-027 With MUL_EARLY_TERM_EN defined: RUN -> DONE also on any edge where the shifted mplier (mplier>>1) is zero; minimum one RUN cycle (b=0 or b=1 -> done in cycle 2).
REQ-028 Without MUL_EARLY_TERM_EN: exactly n RUN cycles regardless of operand values; latency fixed per REQ-021.
REQ-029 Product value SHALL be identical in both configurations.

Verification (n=8)
REQ-030 a=3, b=5, start cycle 0 -> stall 1 in cycles 0..8, done=w=1 only in cycle 9, product=16'h000F from cycle 9 on.
REQ-031 a=8'hFF, b=8'hFF -> product=16'hFE01 in cycle 9 (both configs, b MSB set so no early exit).
REQ-032 start held high cycles 0..12 with a=2, b=4 then a=7, b=7 from cycle 3 -> single done in cycle 9, product=16'h0008; second accept in cycle 10, done cycle 19, product=16'h0031.
REQ-033 reset pulsed in cycle 4 of a=9, b=9 -> state IDLE immediately, no done, product=0, busy=0; fresh start cycle 6 completes normally in cycle 15 with 16'h0051.
REQ-034 MUL_EARLY_TERM_EN, a=6, b=1 -> done cycle 2, product=16'h0006; same stimulus without macro -> done cycle 9, product=16'h0006.
REQ-035 a=0, b=8'h80 -> product=16'h0000, done cycle 9 in both configs.
